// File: rtl/snn_pkg.sv
// Shared types and helpers for the LIF network output-side spike decoder.
// Provides the decoder FSM state type, default widths and the saturating
// increment helper used by every per-channel spike counter.
package snn_pkg;

  localparam int DEF_N_CH  = 2;
  localparam int DEF_WIN_W = 8;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } dec_state_t;

  // Increment (0 or 1) to add to a saturating counter: a spike adds one
  // unless the counter already sits at its all-ones ceiling.
  function automatic logic sat_inc(input logic at_max, input logic spike);
    return spike & ~at_max;
  endfunction

endpackage

// File: rtl/spike_counter.sv
// Single-channel saturating spike counter. Cleared at the start of a window,
// advanced by one per enabled cycle with a spike, sticking at 2^CNT_W-1.
// The next-count value is exported so the parent can capture the final
// window result on the same edge that the last spike is counted.
module spike_counter
  import snn_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic             i_spike,
  output logic [CNT_W-1:0] o_count_nxt
);

  logic [CNT_W-1:0] r_count;
  logic             w_at_max;
  logic [CNT_W-1:0] w_nxt;

  assign w_at_max    = &r_count;
  assign w_nxt       = r_count + {{(CNT_W-1){1'b0}}, sat_inc(w_at_max, i_spike)};
  assign o_count_nxt = w_nxt;

  // Count storage: clear wins over enable so a new window always starts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_count <= '0;
    else if (i_clear) r_count <= '0;
    else if (i_en)    r_count <= w_nxt;
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: counts spikes per channel over a programmable window
// and presents the per-channel counts on a valid/ready output.
// Optional feature macro: SPIKE_DEC_ARGMAX_EN -- when defined, 'winner'
// reports the highest-count channel (ties to the lowest index); otherwise
// 'winner' is tied to zero and no comparator is built.
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int WIN_W = DEF_WIN_W,
  parameter int CNT_W = DEF_CNT_W,
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       spike_in,
  input  logic [WIN_W-1:0]      win_len,
  input  logic                  start,
  output logic                  busy,
  output logic [N_CH*CNT_W-1:0] rate_out,
  output logic                  rate_valid,
  input  logic                  rate_ready,
  output logic [IDX_W-1:0]      winner
);

  dec_state_t             r_state;
  logic [WIN_W-1:0]       r_timer;
  logic                   r_busy;
  logic                   r_valid;
  logic [N_CH*CNT_W-1:0]  r_rate;
  logic [IDX_W-1:0]       r_winner;

  logic                   w_accept;
  logic                   w_counting;
  logic                   w_last;
  logic [N_CH*CNT_W-1:0]  w_cnt_nxt;
  logic [IDX_W-1:0]       w_argmax;

  assign w_accept   = (r_state == IDLE) && start && (win_len != '0);
  assign w_counting = (r_state == COUNT);
  assign w_last     = w_counting && (r_timer == {{(WIN_W-1){1'b0}}, 1'b1});

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    spike_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk         (clk),
      .rst         (rst),
      .i_clear     (w_accept),
      .i_en        (w_counting),
      .i_spike     (spike_in[g]),
      .o_count_nxt (w_cnt_nxt[g*CNT_W +: CNT_W])
    );
  end

`ifdef SPIKE_DEC_ARGMAX_EN
  logic [CNT_W-1:0] w_best;

  // Argmax over the final counts; strict '>' keeps ties on the lowest index.
  always_comb begin
    w_best   = w_cnt_nxt[0 +: CNT_W];
    w_argmax = '0;
    for (int i = 1; i < N_CH; i++) begin
      if (w_cnt_nxt[i*CNT_W +: CNT_W] > w_best) begin
        w_best   = w_cnt_nxt[i*CNT_W +: CNT_W];
        w_argmax = IDX_W'(i);
      end
    end
  end
`else
  assign w_argmax = '0;
`endif

  // Window FSM with registered outputs; results are captured on the HOLD entry edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_rate   <= '0;
      r_winner <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_timer <= win_len;
            r_busy  <= 1'b1;
            r_state <= COUNT;
          end
        end
        COUNT: begin
          r_timer <= r_timer - 1'b1;
          if (w_last) begin
            r_rate   <= w_cnt_nxt;
            r_winner <= w_argmax;
            r_valid  <= 1'b1;
            r_state  <= HOLD;
          end
        end
        HOLD: begin
          if (rate_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign rate_valid = r_valid;
  assign rate_out   = r_rate;
  assign winner     = r_winner;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Testbench for spike_rate_decoder (N_CH=2, WIN_W=8, CNT_W=8).
// Expected window results are pushed to a scoreboard queue as spikes are
// driven and popped when the decoder presents rate_valid.
module tb_spike_rate_decoder;

  typedef struct packed {
    logic [15:0] rate;
    logic        win;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [1:0]  spike_in;
  logic [7:0]  win_len;
  logic        start;
  logic        busy;
  logic [15:0] rate_out;
  logic        rate_valid;
  logic        rate_ready;
  logic        winner;

  exp_t exp_q[$];
  exp_t e;
  int   n_pass;
  int   n_total;

  spike_rate_decoder #(.N_CH(2), .WIN_W(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .spike_in   (spike_in),
    .win_len    (win_len),
    .start      (start),
    .busy       (busy),
    .rate_out   (rate_out),
    .rate_valid (rate_valid),
    .rate_ready (rate_ready),
    .winner     (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one window: ch0 spikes on its first n0 cycles, ch1 on its first n1
  // (or random spikes when rnd). Pushes the modelled result; flags any early valid.
  task automatic drive_window(input int wl, input int n0, input int n1,
                              input bit rnd, output bit early);
    logic [7:0] m0;
    logic [7:0] m1;
    logic [1:0] s;
    exp_t       x;
    m0 = 8'd0;
    m1 = 8'd0;
    early = 1'b0;
    @(posedge clk); #1;
    start   = 1'b1;
    win_len = 8'(wl);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < wl; k++) begin
      if (rnd) s = 2'($urandom_range(0, 3));
      else     s = {(k < n1), (k < n0)};
      spike_in = s;
      if (s[0] && m0 != 8'hFF) m0 = m0 + 8'd1;
      if (s[1] && m1 != 8'hFF) m1 = m1 + 8'd1;
      if (rate_valid) early = 1'b1;
      @(posedge clk); #1;
    end
    spike_in = 2'b00;
    x.rate = {m1, m0};
`ifdef SPIKE_DEC_ARGMAX_EN
    x.win = (m1 > m0);
`else
    x.win = 1'b0;
`endif
    exp_q.push_back(x);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; win_len = 8'd0; spike_in = 2'b00; rate_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_total++;
    if (busy !== 1'b0 || rate_valid !== 1'b0 || rate_out !== 16'h0 || winner !== 1'b0)
      $display("FAIL reset_state busy=%b valid=%b rate=%h win=%b expected 0/0/0000/0",
               busy, rate_valid, rate_out, winner);
    else n_pass++;
  endtask

  task automatic test_basic_window();
    bit early;
    drive_window(10, 10, 0, 1'b0, early);
    n_total++;
    if (early !== 1'b0 || rate_valid !== 1'b1)
      $display("FAIL basic_latency early=%b valid=%b expected early=0 valid=1 at +11", early, rate_valid);
    else n_pass++;
    e = exp_q.pop_front();
    n_total++;
    if (rate_out !== e.rate || winner !== e.win)
      $display("FAIL basic_counts rate=%h win=%b expected rate=%h win=%b", rate_out, winner, e.rate, e.win);
    else n_pass++;
    n_total++;
    if (rate_out !== 16'h000A)
      $display("FAIL basic_ch0_10 rate=%h expected 000a", rate_out);
    else n_pass++;
    rate_ready = 1'b1;
    @(posedge clk); #1;
    rate_ready = 1'b0;
    n_total++;
    if (rate_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_handshake valid=%b busy=%b expected 0/0", rate_valid, busy);
    else n_pass++;
  endtask

  task automatic test_saturation_zero_len();
    bit early;
    drive_window(255, 0, 255, 1'b0, early);
    e = exp_q.pop_front();
    n_total++;
    if (early !== 1'b0 || rate_valid !== 1'b1 || rate_out !== e.rate || rate_out[15:8] !== 8'hFF)
      $display("FAIL sat_255 early=%b valid=%b rate=%h expected early=0 valid=1 rate=%h",
               early, rate_valid, rate_out, e.rate);
    else n_pass++;
    rate_ready = 1'b1;
    @(posedge clk); #1;
    rate_ready = 1'b0;
    start = 1'b1; win_len = 8'd0; spike_in = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_total++;
      if (busy !== 1'b0 || rate_valid !== 1'b0 || rate_out !== e.rate)
        $display("FAIL zero_len_ignored busy=%b valid=%b rate=%h expected 0/0/%h",
                 busy, rate_valid, rate_out, e.rate);
      else n_pass++;
    end
    start = 1'b0; spike_in = 2'b00;
  endtask

  task automatic test_hold_backpressure();
    bit early;
    drive_window(6, 0, 0, 1'b1, early);
    e = exp_q.pop_front();
    n_total++;
    if (early !== 1'b0 || rate_valid !== 1'b1 || rate_out !== e.rate || winner !== e.win)
      $display("FAIL hold_entry valid=%b rate=%h win=%b expected 1/%h/%b",
               rate_valid, rate_out, winner, e.rate, e.win);
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      start = 1'b1; win_len = 8'd3; spike_in = k[0] ? 2'b11 : 2'b00; rate_ready = 1'b0;
      @(posedge clk); #1;
      n_total++;
      if (rate_valid !== 1'b1 || busy !== 1'b1 || rate_out !== e.rate || winner !== e.win)
        $display("FAIL hold_stable cyc=%0d valid=%b busy=%b rate=%h expected 1/1/%h",
                 k, rate_valid, busy, rate_out, e.rate);
      else n_pass++;
    end
    start = 1'b0; spike_in = 2'b00; rate_ready = 1'b1;
    @(posedge clk); #1;
    rate_ready = 1'b0;
    n_total++;
    if (rate_valid !== 1'b0 || busy !== 1'b0 || rate_out !== e.rate)
      $display("FAIL hold_release valid=%b busy=%b rate=%h expected 0/0/%h",
               rate_valid, busy, rate_out, e.rate);
    else n_pass++;
  endtask

  task automatic test_reset_in_hold();
    bit early;
    drive_window(4, 4, 1, 1'b0, early);
    e = exp_q.pop_front();
    n_total++;
    if (rate_valid !== 1'b1 || rate_out !== e.rate)
      $display("FAIL pre_reset_hold valid=%b rate=%h expected 1/%h", rate_valid, rate_out, e.rate);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (busy !== 1'b0 || rate_valid !== 1'b0 || rate_out !== 16'h0 || winner !== 1'b0)
      $display("FAIL async_reset busy=%b valid=%b rate=%h win=%b expected 0/0/0000/0",
               busy, rate_valid, rate_out, winner);
    else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_mid_window_reset();
    bit early;
    @(posedge clk); #1;
    start = 1'b1; win_len = 8'd8; spike_in = 2'b11;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (busy !== 1'b0 || rate_valid !== 1'b0 || rate_out !== 16'h0)
      $display("FAIL mid_window_reset busy=%b valid=%b rate=%h expected 0/0/0000", busy, rate_valid, rate_out);
    else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    spike_in = 2'b00;
    repeat (10) @(posedge clk);
    #1;
    n_total++;
    if (rate_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL stays_idle valid=%b busy=%b expected 0/0", rate_valid, busy);
    else n_pass++;
    drive_window(4, 4, 4, 1'b0, early);
    e = exp_q.pop_front();
    n_total++;
    if (early !== 1'b0 || rate_valid !== 1'b1 || rate_out !== e.rate || rate_out !== 16'h0404)
      $display("FAIL fresh_window valid=%b rate=%h expected 1/%h", rate_valid, rate_out, e.rate);
    else n_pass++;
    rate_ready = 1'b1;
    @(posedge clk); #1 rate_ready = 1'b0;
  endtask

  task automatic test_argmax();
    bit early;
    int n0_tab[3] = '{3, 5, 6};
    int n1_tab[3] = '{7, 5, 2};
    for (int t = 0; t < 3; t++) begin
      drive_window(8, n0_tab[t], n1_tab[t], 1'b0, early);
      e = exp_q.pop_front();
      n_total++;
      if (rate_valid !== 1'b1 || rate_out !== e.rate || winner !== e.win)
        $display("FAIL argmax case=%0d valid=%b rate=%h win=%b expected 1/%h/%b",
                 t, rate_valid, rate_out, winner, e.rate, e.win);
      else n_pass++;
      rate_ready = 1'b1;
      @(posedge clk); #1 rate_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    bit early;
    for (int t = 0; t < 4; t++) begin
      drive_window(int'($urandom_range(1, 20)), 0, 0, 1'b1, early);
      e = exp_q.pop_front();
      n_total++;
      if (early !== 1'b0 || rate_valid !== 1'b1 || rate_out !== e.rate || winner !== e.win)
        $display("FAIL back_to_back win=%0d valid=%b rate=%h win=%b expected 1/%h/%b",
                 t, rate_valid, rate_out, winner, e.rate, e.win);
      else n_pass++;
      rate_ready = 1'b1;
      @(posedge clk); #1 rate_ready = 1'b0;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_basic_window();
    test_saturation_zero_len();
    test_hold_backpressure();
    test_reset_in_hold();
    test_mid_window_reset();
    test_argmax();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
